// File: rtl/moving_avg_pkg.sv
// moving_avg_pkg: shared helpers for moving_avg_mc (sum width, channel
// slicing, window-shift clamp).
package moving_avg_pkg;

   // Running-sum width: one sample plus headroom for 2^max_shift samples.
   function automatic int sum_width(input int data_width, input int max_shift);
      return data_width + max_shift;
   endfunction

   // LSB position of channel ch inside a packed multi-channel word.
   function automatic int ch_lsb(input int ch, input int data_width);
      return ch * data_width;
   endfunction

   // Requested window log2 limited to the delay-line depth.
   function automatic int unsigned clamp_shift(input int unsigned ws, input int unsigned max_shift);
      int unsigned r;
      if (ws > max_shift) begin
         r = max_shift;
      end else begin
         r = ws;
      end
      return r;
   endfunction

endpackage

// File: rtl/ram_2port.sv
// ram_2port: simple dual-port RAM, one write port and one registered read
// port. Read-first: a read of the address being written returns the old word.
module ram_2port #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 64,
   parameter int AW    = 6
) (
   input  logic             clock,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_re,
   input  logic [AW-1:0]    i_raddr,
   output logic [WIDTH-1:0] o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rdata;

   // Registered read of the old contents, then write of the new word.
   always_ff @(posedge clock) begin
      if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/moving_avg_mc.sv
// moving_avg_mc: multi-channel moving average over a runtime window of
// 2^win_shift samples, sharing one delay line across all channels.
// Optional rounding (round half up) is enabled by defining
// MOVING_AVG_MC_ROUND_EN; by default the average truncates toward -inf.
module moving_avg_mc
   import moving_avg_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_CH     = 2,
   parameter int MAX_SHIFT  = 6,
   parameter int SIGNED     = 1
) (
   input  logic                           clock,
   input  logic                           rstn,
   input  logic                           enable,
   input  logic                           restart,
   input  logic [$clog2(MAX_SHIFT+1)-1:0] win_shift,
   input  logic [NUM_CH*DATA_WIDTH-1:0]   data_in,
   input  logic                           input_strobe,
   output logic [NUM_CH*DATA_WIDTH-1:0]   data_out,
   output logic                           output_strobe,
   output logic                           full
);

   localparam int SW    = sum_width(DATA_WIDTH, MAX_SHIFT);
   localparam int DEPTH = 1 << MAX_SHIFT;
   localparam int AW    = (MAX_SHIFT > 0) ? MAX_SHIFT : 1;
   localparam int WSW   = $clog2(MAX_SHIFT + 1);
   localparam int FW    = MAX_SHIFT + 1;
   localparam int BW    = NUM_CH * DATA_WIDTH;

   // window control
   logic              r_init;
   logic [WSW-1:0]    r_shift;
   logic [WSW-1:0]    w_ws_clamped;
   logic [WSW-1:0]    w_shift;
   logic [FW-1:0]     w_win;
   // stage 1
   logic              w_accept;
   logic [AW-1:0]     r_wr_addr;
   logic [AW-1:0]     w_rd_addr;
   logic [FW-1:0]     r_fill;
   logic [FW-1:0]     w_fill_next;
   logic              r_full;
   logic              r_s1_valid;
   logic              r_s1_sub;
   logic              r_s1_emit;
   logic [BW-1:0]     r_s1_data;
   logic [BW-1:0]     w_rd_data;
   // stage 2
   logic [SW-1:0]         r_sum      [NUM_CH];
   logic [SW-1:0]         w_sum_next [NUM_CH];
   logic [DATA_WIDTH-1:0] w_avg      [NUM_CH];
   logic [SW-1:0]         w_rnd;
   logic [BW-1:0]         r_data_out;
   logic                  r_ostrb;

   // Window selection, accept qualification, read address and fill step.
   always_comb begin
      w_ws_clamped = WSW'(clamp_shift(32'(win_shift), MAX_SHIFT));
      // Until the first edge after reset the live input is the window.
      if (r_init) begin
         w_shift = r_shift;
      end else begin
         w_shift = w_ws_clamped;
      end
      w_win     = {{(FW-1){1'b0}}, 1'b1} << w_shift;
      w_accept  = input_strobe & enable & ~restart;
      // At the maximum window this equals the write address (read-first RAM).
      w_rd_addr = r_wr_addr - w_win[AW-1:0];
      if (r_fill == w_win) begin
         w_fill_next = r_fill;
      end else begin
         w_fill_next = r_fill + {{(FW-1){1'b0}}, 1'b1};
      end
   end

   // Rounding offset, per-channel sum update and shifted average.
   always_comb begin
      logic [DATA_WIDTH-1:0] w_new;
      logic [DATA_WIDTH-1:0] w_old;
      logic [SW-1:0]         w_ext_new;
      logic [SW-1:0]         w_ext_old;
      logic [SW-1:0]         w_tot;
`ifdef MOVING_AVG_MC_ROUND_EN
      if (w_shift == {WSW{1'b0}}) begin
         w_rnd = {SW{1'b0}};
      end else begin
         w_rnd = {{(SW-1){1'b0}}, 1'b1} << (w_shift - {{(WSW-1){1'b0}}, 1'b1});
      end
`else
      w_rnd = {SW{1'b0}};
`endif
      for (int c = 0; c < NUM_CH; c++) begin
         w_new     = r_s1_data[ch_lsb(c, DATA_WIDTH) +: DATA_WIDTH];
         w_old     = w_rd_data[ch_lsb(c, DATA_WIDTH) +: DATA_WIDTH];
         w_ext_new = {{MAX_SHIFT{(SIGNED != 0) && w_new[DATA_WIDTH-1]}}, w_new};
         w_ext_old = {{MAX_SHIFT{(SIGNED != 0) && w_old[DATA_WIDTH-1]}}, w_old};
         w_sum_next[c] = r_sum[c] + w_ext_new - (r_s1_sub ? w_ext_old : {SW{1'b0}});
         w_tot = w_sum_next[c] + w_rnd;
         if (SIGNED != 0) begin
            w_avg[c] = DATA_WIDTH'($signed(w_tot) >>> w_shift);
         end else begin
            w_avg[c] = DATA_WIDTH'(w_tot >> w_shift);
         end
      end
   end

   // Window latch, write pointer, fill count and stage-1 capture.
   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         r_init     <= 1'b0;
         r_shift    <= {WSW{1'b0}};
         r_wr_addr  <= {AW{1'b0}};
         r_fill     <= {FW{1'b0}};
         r_full     <= 1'b0;
         r_s1_valid <= 1'b0;
         r_s1_sub   <= 1'b0;
         r_s1_emit  <= 1'b0;
         r_s1_data  <= {BW{1'b0}};
      end else if (restart) begin
         r_init     <= 1'b1;
         r_shift    <= w_ws_clamped;
         r_fill     <= {FW{1'b0}};
         r_full     <= 1'b0;
         r_s1_valid <= 1'b0;
      end else begin
         if (!r_init) begin
            r_init  <= 1'b1;
            r_shift <= w_ws_clamped;
         end
         if (enable) begin
            r_s1_valid <= w_accept;
         end
         if (w_accept) begin
            r_s1_data <= data_in;
            r_s1_sub  <= (r_fill == w_win);
            r_s1_emit <= (r_fill >= (w_win - {{(FW-1){1'b0}}, 1'b1}));
            r_wr_addr <= r_wr_addr + {{(AW-1){1'b0}}, 1'b1};
            r_fill    <= w_fill_next;
            r_full    <= (w_fill_next == w_win);
         end
      end
   end

   // Stage 2: running sums, averaged output and result strobe.
   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         for (int c = 0; c < NUM_CH; c++) begin
            r_sum[c] <= {SW{1'b0}};
         end
         r_data_out <= {BW{1'b0}};
         r_ostrb    <= 1'b0;
      end else if (restart) begin
         for (int c = 0; c < NUM_CH; c++) begin
            r_sum[c] <= {SW{1'b0}};
         end
         r_ostrb <= 1'b0;
      end else if (enable) begin
         r_ostrb <= r_s1_valid & r_s1_emit;
         if (r_s1_valid) begin
            for (int c = 0; c < NUM_CH; c++) begin
               r_sum[c] <= w_sum_next[c];
            end
         end
         if (r_s1_valid & r_s1_emit) begin
            for (int c = 0; c < NUM_CH; c++) begin
               r_data_out[ch_lsb(c, DATA_WIDTH) +: DATA_WIDTH] <= w_avg[c];
            end
         end
      end
   end

   // Shared delay line holding the last 2^MAX_SHIFT accepted words.
   ram_2port #(
      .WIDTH (BW),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_delay (
      .clock   (clock),
      .i_we    (w_accept),
      .i_waddr (r_wr_addr),
      .i_wdata (data_in),
      .i_re    (w_accept),
      .i_raddr (w_rd_addr),
      .o_rdata (w_rd_data)
   );

   // A held result is only presented in an enabled cycle.
   assign output_strobe = r_ostrb & enable;
   assign data_out      = r_data_out;
   assign full          = r_full;

endmodule

// File: tb/tb_moving_avg_mc.sv
// tb_moving_avg_mc: directed table, corner sequences and random stimulus for
// moving_avg_mc against a queue-based reference model.
module tb_moving_avg_mc;

   localparam int DW  = 16;
   localparam int NCH = 2;
   localparam int MS  = 6;
   localparam int WSW = 3;
   localparam int BW  = NCH * DW;

   typedef struct {
      bit          en;
      bit          rs;
      bit          st;
      int          ws;
      logic [DW-1:0] d0;
      logic [DW-1:0] d1;
      bit          os;
      logic [DW-1:0] e0;
      logic [DW-1:0] e1;
   } vec_t;

   logic           clock = 1'b0;
   logic           rstn = 1'b1;
   logic           enable = 1'b0;
   logic           restart = 1'b0;
   logic [WSW-1:0] win_shift = 3'd2;
   logic [BW-1:0]  data_in = '0;
   logic           input_strobe = 1'b0;
   logic [BW-1:0]  data_out;
   logic           output_strobe;
   logic           full;

   int vectors = 0;
   int miscompares = 0;

   // reference model state
   int            m_w = 1;
   logic [BW-1:0] m_hist[$];
   int            m_cnt[$];
   logic [BW-1:0] m_val[$];

   vec_t tbl[15];

   always #5 clock = ~clock;

   moving_avg_mc #(
      .DATA_WIDTH (DW),
      .NUM_CH     (NCH),
      .MAX_SHIFT  (MS),
      .SIGNED     (1)
   ) dut (
      .clock         (clock),
      .rstn          (rstn),
      .enable        (enable),
      .restart       (restart),
      .win_shift     (win_shift),
      .data_in       (data_in),
      .input_strobe  (input_strobe),
      .data_out      (data_out),
      .output_strobe (output_strobe),
      .full          (full)
   );

   task automatic chk(input string nm, input longint act, input longint exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic longint sx(input logic [DW-1:0] v);
      return longint'($signed(v));
   endfunction

   function automatic int clampw(input logic [WSW-1:0] w);
      return (int'(w) > MS) ? MS : int'(w);
   endfunction

   function automatic logic [BW-1:0] rnd();
      return BW'($urandom());
   endfunction

   function automatic vec_t mk(input bit en, input bit rs, input bit st, input int ws,
                               input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                               input bit os, input logic [DW-1:0] e0, input logic [DW-1:0] e1);
      vec_t v;
      v.en = en; v.rs = rs; v.st = st; v.ws = ws;
      v.d0 = d0; v.d1 = d1; v.os = os; v.e0 = e0; v.e1 = e1;
      return v;
   endfunction

   // Average of the latest m_w samples, floor division (optionally rounded).
   function automatic logic [BW-1:0] ref_avg();
      logic [BW-1:0] r;
      logic [BW-1:0] e;
      logic [DW-1:0] smp;
      longint s;
      longint q;
      r = '0;
      for (int c = 0; c < NCH; c++) begin
         s = 0;
         for (int k = 0; k < m_w; k++) begin
            e   = m_hist[m_hist.size() - 1 - k];
            smp = e[c*DW +: DW];
            s  += sx(smp);
         end
`ifdef MOVING_AVG_MC_ROUND_EN
         if (m_w > 1) s += m_w / 2;
`endif
         q = s / m_w;
         if ((s % m_w != 0) && (s < 0)) q = q - 1;
         r[c*DW +: DW] = q[DW-1:0];
      end
      return r;
   endfunction

   task automatic model_reset();
      m_hist.delete();
      m_cnt.delete();
      m_val.delete();
      m_w = 1 << clampw(win_shift);
   endtask

   // Compare this cycle's outputs against the model, then absorb the inputs.
   task automatic model_cycle();
      bit            exp_os;
      logic [BW-1:0] exp_v;
      exp_os = 1'b0;
      exp_v  = '0;
      chk("full", longint'(full), longint'(m_hist.size() >= m_w));
      if (enable) begin
         for (int i = 0; i < m_cnt.size(); i++) m_cnt[i] = m_cnt[i] - 1;
         if (m_cnt.size() > 0 && m_cnt[0] == 0) begin
            exp_os = 1'b1;
            exp_v  = m_val.pop_front();
            void'(m_cnt.pop_front());
         end
      end
      chk("ostrb", longint'(output_strobe), longint'(exp_os));
      if (exp_os && output_strobe) begin
         for (int c = 0; c < NCH; c++) begin
            chk("dout", sx(data_out[c*DW +: DW]), sx(exp_v[c*DW +: DW]));
         end
      end
      if (restart) begin
         model_reset();
      end else if (enable && input_strobe) begin
         m_hist.push_back(data_in);
         if (m_hist.size() > 64) void'(m_hist.pop_front());
         if (m_hist.size() >= m_w) begin
            m_cnt.push_back(2);
            m_val.push_back(ref_avg());
         end
      end
   endtask

   task automatic cyc(input bit en, input bit rs, input bit st, input int ws, input logic [BW-1:0] d);
      @(posedge clock);
      #1;
      enable       = en;
      restart      = rs;
      input_strobe = st;
      win_shift    = ws[WSW-1:0];
      data_in      = d;
      #1;
      model_cycle();
   endtask

   initial begin
      int nos;
      // fill (W=4) then signed W=2 sequence
      tbl[0]  = mk(1'b1, 1'b1, 1'b0, 2, 16'd0,  16'd0,   1'b0, 16'd0,  16'd0);
      tbl[1]  = mk(1'b1, 1'b0, 1'b1, 2, 16'd4,  16'd100, 1'b0, 16'd0,  16'd0);
      tbl[2]  = mk(1'b1, 1'b0, 1'b1, 2, 16'd8,  16'd200, 1'b0, 16'd0,  16'd0);
      tbl[3]  = mk(1'b1, 1'b0, 1'b1, 2, 16'd12, 16'd300, 1'b0, 16'd0,  16'd0);
      tbl[4]  = mk(1'b1, 1'b0, 1'b1, 2, 16'd16, 16'd400, 1'b0, 16'd0,  16'd0);
      tbl[5]  = mk(1'b1, 1'b0, 1'b1, 2, 16'd20, 16'd500, 1'b0, 16'd0,  16'd0);
      tbl[6]  = mk(1'b1, 1'b0, 1'b0, 2, 16'd0,  16'd0,   1'b1, 16'd10, 16'd250);
      tbl[7]  = mk(1'b1, 1'b0, 1'b0, 2, 16'd0,  16'd0,   1'b1, 16'd14, 16'd350);
      tbl[8]  = mk(1'b1, 1'b0, 1'b0, 2, 16'd0,  16'd0,   1'b0, 16'd0,  16'd0);
      tbl[9]  = mk(1'b1, 1'b1, 1'b0, 1, 16'd0,  16'd0,   1'b0, 16'd0,  16'd0);
      tbl[10] = mk(1'b1, 1'b0, 1'b1, 1, 16'd0,  16'hFFFD, 1'b0, 16'd0, 16'd0);
      tbl[11] = mk(1'b1, 1'b0, 1'b1, 1, 16'd1,  16'hFFFC, 1'b0, 16'd0, 16'd0);
      tbl[12] = mk(1'b1, 1'b0, 1'b0, 1, 16'd0,  16'd0,   1'b0, 16'd0,  16'd0);
`ifdef MOVING_AVG_MC_ROUND_EN
      tbl[13] = mk(1'b1, 1'b0, 1'b0, 1, 16'd0,  16'd0,   1'b1, 16'd1,  16'hFFFD);
`else
      tbl[13] = mk(1'b1, 1'b0, 1'b0, 1, 16'd0,  16'd0,   1'b1, 16'd0,  16'hFFFC);
`endif
      tbl[14] = mk(1'b1, 1'b0, 1'b0, 1, 16'd0,  16'd0,   1'b0, 16'd0,  16'd0);

      // power-on reset
      #2 rstn = 1'b0;
      #1;
      chk("rst_dout", longint'(data_out), 0);
      chk("rst_ostrb", longint'(output_strobe), 0);
      chk("rst_full", longint'(full), 0);
      repeat (2) @(posedge clock);
      #3 rstn = 1'b1;
      model_reset();

      // directed table
      for (int i = 0; i < 15; i++) begin
         cyc(tbl[i].en, tbl[i].rs, tbl[i].st, tbl[i].ws, {tbl[i].d1, tbl[i].d0});
         chk("tbl_ostrb", longint'(output_strobe), longint'(tbl[i].os));
         if (tbl[i].os) begin
            chk("tbl_ch0", sx(data_out[DW-1:0]), sx(tbl[i].e0));
            chk("tbl_ch1", sx(data_out[BW-1:DW]), sx(tbl[i].e1));
         end
      end

      // restart with coincident strobe at W=8
      cyc(1'b1, 1'b1, 1'b0, 3, '0);
      for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, 1'b1, 3, rnd());
      cyc(1'b1, 1'b1, 1'b1, 3, rnd());
      nos = 0;
      for (int i = 0; i < 7; i++) begin
         cyc(1'b1, 1'b0, 1'b1, 3, rnd());
         if (output_strobe) nos++;
      end
      chk("rst_quiet", nos, 0);
      cyc(1'b1, 1'b0, 1'b1, 3, rnd());
      chk("rst_nofull", longint'(full), 0);
      cyc(1'b1, 1'b0, 1'b0, 3, '0);
      cyc(1'b1, 1'b0, 1'b0, 3, '0);
      chk("rst_8th", longint'(output_strobe), 1);

      // window change ignored without restart, taken on restart
      cyc(1'b1, 1'b1, 1'b0, 2, '0);
      for (int i = 0; i < 6; i++) begin
         cyc(1'b1, 1'b0, 1'b1, 3, rnd());
         if (i == 4) chk("win4_full", longint'(full), 1);
      end
      repeat (3) cyc(1'b1, 1'b0, 1'b0, 3, '0);
      cyc(1'b1, 1'b1, 1'b0, 3, '0);
      for (int i = 0; i < 10; i++) begin
         cyc(1'b1, 1'b0, 1'b1, 3, rnd());
         if (i == 7) chk("win8_nofull", longint'(full), 0);
      end
      repeat (3) cyc(1'b1, 1'b0, 1'b0, 3, '0);

      // stall at the maximum window with continuous strobes
      cyc(1'b1, 1'b1, 1'b0, 6, '0);
      for (int i = 0; i < 205; i++) begin
         cyc(!(i >= 100 && i < 105), 1'b0, 1'b1, 6, rnd());
      end
      repeat (3) cyc(1'b1, 1'b0, 1'b0, 6, '0);

      // randomized stimulus, including clamped window values
      for (int i = 0; i < 800; i++) begin
         cyc(($urandom % 8) != 0, ($urandom % 60) == 0, ($urandom % 4) != 0,
             int'($urandom_range(0, 7)), rnd());
      end

      // asynchronous reset between clock edges
      cyc(1'b1, 1'b1, 1'b0, 1, '0);
      for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b1, 1, rnd());
      #2;
      rstn         = 1'b0;
      input_strobe = 1'b0;
      restart      = 1'b0;
      #1;
      chk("arst_dout", longint'(data_out), 0);
      chk("arst_ostrb", longint'(output_strobe), 0);
      chk("arst_full", longint'(full), 0);
      @(posedge clock);
      @(posedge clock);
      #3 rstn = 1'b1;
      model_reset();
      nos = 0;
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 1'b0, 1'b0, 1, '0);
         if (output_strobe) nos++;
      end
      chk("arst_quiet", nos, 0);
      for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b1, 1, rnd());
      repeat (3) cyc(1'b1, 1'b0, 1'b0, 1, '0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/moving_avg_mc.md
MOVING_AVG_MC -- requirements
Module: moving_avg_mc

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: sample width per channel.
REQ-002 SHALL have parameter NUM_CH, default 2: independent channels averaged in lockstep.
REQ-003 SHALL have parameter MAX_SHIFT, default 6: log2 of maximum window; delay depth 2^MAX_SHIFT.
REQ-004 SHALL have parameter SIGNED, default 1: 1 = two's-complement samples, 0 = unsigned.
REQ-005 SHALL have port clock, input, 1: single clock, all logic on rising edge.
REQ-006 SHALL have port rstn, input, 1: reset is asynchronous and active-low.
REQ-007 SHALL have port enable, input, 1: when low, strobes ignored, all state held.
REQ-008 SHALL have port restart, input, 1: synchronous flush of sums, fill count and pipeline; latches win_shift.
REQ-009 SHALL have port win_shift, input, $clog2(MAX_SHIFT+1): runtime window log2, W = 2^win_shift.
REQ-010 SHALL have port data_in, input, NUM_CH*DATA_WIDTH: channel c at bits [c*DATA_WIDTH +: DATA_WIDTH].
REQ-011 SHALL have port input_strobe, input, 1: data_in valid this cycle.
REQ-012 SHALL have port data_out, output, NUM_CH*DATA_WIDTH: per-channel average, same packing.
REQ-013 SHALL have port output_strobe, output, 1: data_out valid, one-cycle pulse per result.
REQ-014 SHALL have port full, output, 1: window filled since last restart/reset.

Function
REQ-015 SHALL keep per channel a running sum of width DATA_WIDTH+MAX_SHIFT, sign- or zero-extended per SIGNED; overflow impossible by construction.
REQ-016 SHALL use active window W_act = 2^win_shift_latched; win_shift values above MAX_SHIFT clamp to MAX_SHIFT.
REQ-017 SHALL change W_act only at reset or restart; win_shift changes at other times are ignored.
REQ-018 SHALL implement a two-stage pipeline: stage 1 writes new samples at wr_addr and reads sample at wr_addr - W_act (mod depth); stage 2 updates sums and registers data_out.
REQ-019 SHALL, per accepted strobe (input_strobe & enable & !restart), add the new sample and, once fill_cnt >= W_act, subtract the sample W_act strobes old.
REQ-020 SHALL produce data_out = sum >> win_shift (arithmetic if SIGNED) covering exactly the latest W_act samples, including the current one.
REQ-021 SHALL assert output_strobe exactly 2 enabled cycles after an accepted strobe whose 0-based index since restart is >= W_act-1; never otherwise.
REQ-022 SHALL accept back-to-back strobes every cycle with no bubbles.
REQ-023 SHALL keep fill_cnt saturating at W_act; full = (fill_cnt == W_act); wr_addr wraps modulo 2^MAX_SHIFT.
REQ-024 SHALL, when restart and input_strobe coincide, give restart priority and discard the sample; in-flight pipeline results are dropped (no output_strobe).
REQ-025 SHALL, while enable is low, freeze the pipeline and hold output_strobe low; pending results emerge after enable returns.
REQ-026 SHALL, with win_shift = 0, pass each sample through with 2-cycle latency, output_strobe from the first sample.

Reset
REQ-027 SHALL on rstn low asynchronously clear sums, wr_addr, fill_cnt, pipeline valids, data_out = 0, output_strobe = 0, full = 0, and latch win_shift on deassertion edge.
REQ-028 SHALL require no delay-line clearing; stale entries are never summed because of fill_cnt gating.

Configuration
REQ-029 SHALL with MOVING_AVG_MC_ROUND_EN defined add 2^(win_shift-1) (none when win_shift = 0) to the sum before shifting (round half up).
REQ-030 SHALL without MOVING_AVG_MC_ROUND_EN truncate toward minus infinity (plain shift).

Structure
REQ-031 SHALL place sum-width function, channel-slice helpers and clamp constant in shared package moving_avg_pkg.
REQ-032 SHALL instantiate one sub-module ram_2port, width NUM_CH*DATA_WIDTH, depth 2^MAX_SHIFT, as the shared delay line.

Verification
REQ-033 SHALL cover fill: W=4, ch0 samples 4,8,12,16,20 -> first output_strobe after 4th sample, outputs 10 then 14.
REQ-034 SHALL cover signed: SIGNED=1, W=2, ch1 -3,-4 -> -4 truncated, -3 with MOVING_AVG_MC_ROUND_EN.
REQ-035 SHALL cover restart: W=8 running, restart with coincident strobe -> no output for next 7 strobes, full = 0, 8th strobe yields average of new samples only.
REQ-036 SHALL cover window change: win_shift 2->3 without restart -> W stays 4; after restart -> W = 8.
REQ-037 SHALL cover stalls: enable low 5 cycles mid-stream at MAX_SHIFT window, continuous strobes, 200 samples -> outputs match reference model, wraparound of wr_addr exercised.
REQ-038 SHALL cover async reset mid-stream: rstn low between clock edges -> outputs 0 immediately, no spurious output_strobe afterwards.
